// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: configuration, serial stream and status signals of the sequence-detect controller
interface seq_det_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    logic                       cfg_we;
    logic [PAT_W-1:0]           cfg_pattern;
    logic [$clog2(PAT_W+1)-1:0] cfg_len;
    logic                       cfg_overlap;
    logic [CNT_W-1:0]           cfg_target;
    logic [TMO_W-1:0]           cfg_timeout;
    logic                       start;
    logic                       abort;
    logic                       x;
    logic                       x_valid;
    logic                       detect;
    logic [CNT_W-1:0]           match_cnt;
    logic                       busy;
    logic                       done;
    logic                       timeout;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output start, abort, x, x_valid,
        input  detect, match_cnt, busy, done, timeout
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  start, abort, x, x_valid,
        output detect, match_cnt, busy, done, timeout
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with match target and inactivity supervision.
// Define SEQ_DET_CTRL_TIMEOUT_EN to build the timer, timeout limit register and TMO state.
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input logic clk,
    input logic reset,
    seq_det_ctrl_if.slave bus
);
    localparam int LW = $clog2(PAT_W + 1);
    localparam logic [LW:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

    state_t state, nxt;
    logic [PAT_W-1:0] pattern, hist, hx, mask;
    logic [LW-1:0] len, fill;
    logic [CNT_W-1:0] target, cnt, cnt_inc;
    logic overlap, running, arm, hit, reach, expire, detect, done;

    assign running = state == RUN;
    assign arm = bus.start && !bus.abort && !running && len != '0 && len <= LW'(PAT_W);
    assign hx = {hist[PAT_W-2:0], bus.x};
    assign mask = ~({PAT_W{1'b1}} << len);
    // abort outranks a completing bit, so it suppresses the match entirely
    assign hit = running && bus.x_valid && !bus.abort && ({1'b0, fill} + ONE >= {1'b0, len})
                 && ((hx ^ pattern) & mask) == '0;
    assign cnt_inc = cnt + CNT_W'(1);
    assign reach = hit && target != '0 && cnt_inc == target;

    always_comb begin
        nxt = state;
        if (running) nxt = bus.abort ? IDLE : reach ? DONE : expire ? TMO : RUN;
        else if (bus.abort) nxt = IDLE;
        else if (arm) nxt = RUN;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern <= PAT_W'(4'b1010);
            len     <= LW'(4);
            overlap <= 1'b1;
            target  <= '0;
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            detect  <= 1'b0;
            done    <= 1'b0;
        end else begin
            detect <= hit;
            if (bus.cfg_we && !running) begin
                pattern <= bus.cfg_pattern;
                len     <= bus.cfg_len;
                overlap <= bus.cfg_overlap;
                target  <= bus.cfg_target;
            end
            if (arm) begin
                hist <= '0;
                fill <= '0;
                cnt  <= '0;
                done <= 1'b0;
            end else if (running && bus.x_valid && !bus.abort) begin
                hist <= hx;
                fill <= (hit && !overlap) ? '0 : (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
            end
            if (hit && !(target == '0 && cnt == '1)) cnt <= cnt_inc;
            if (reach) done <= 1'b1;
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_lim, timer;
    logic tmo_flag;

    // a match on the expiry cycle restarts the timer instead of timing out
    assign expire = running && !hit && tmo_lim != '0 && timer == tmo_lim - TMO_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_lim  <= '0;
            timer    <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (bus.cfg_we && !running) tmo_lim <= bus.cfg_timeout;
            timer    <= (arm || hit) ? '0 : running ? timer + TMO_W'(1) : timer;
            tmo_flag <= arm ? 1'b0 : (running && nxt == TMO) ? 1'b1 : tmo_flag;
        end
    end

    assign bus.timeout = tmo_flag;
`else
    logic unused_tmo;
    assign unused_tmo  = ^bus.cfg_timeout;
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.detect    = detect;
    assign bus.match_cnt = cnt;
    assign bus.busy      = running;
    assign bus.done      = done;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized checks of seq_det_ctrl against a bit-queue reference model
module tb_seq_det_ctrl;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int checks = 0;
    int errors = 0;

    seq_det_ctrl_if #(.PAT_W(8), .CNT_W(8), .TMO_W(16)) bus ();

    seq_det_ctrl #(.PAT_W(8), .CNT_W(8), .TMO_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // reference model: received bits kept in a queue, pattern compared bit by bit
    bit m_run, m_done, m_tmo, m_det;
    int m_cnt, el;
    bit q[$];
    logic [7:0] m_pat;
    int m_len, m_tgt, m_lim;
    bit m_ovl;

    task automatic m_reset();
        m_run = 0; m_done = 0; m_tmo = 0; m_det = 0; m_cnt = 0; el = 0;
        q.delete();
        m_pat = 8'b1010; m_len = 4; m_ovl = 1; m_tgt = 0; m_lim = 0;
    endtask

    task automatic m_step();
        bit hit;
        hit = 0;
        m_det = 0;
        if (m_run) begin
            if (bus.abort) m_run = 0;
            else begin
                if (bus.x_valid) begin
                    q.push_back(bus.x);
                    if (q.size() > 8) void'(q.pop_front());
                    if (q.size() >= m_len) begin
                        hit = 1;
                        for (int i = 0; i < m_len; i++)
                            if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
                    end
                end
                if (hit) begin
                    m_det = 1;
                    if (!(m_tgt == 0 && m_cnt == 255)) m_cnt++;
                    el = 0;
                    if (!m_ovl) q.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin m_run = 0; m_done = 1; end
                end else begin
                    el++;
                    if (TMO_EN && m_lim != 0 && el == m_lim) begin m_run = 0; m_tmo = 1; end
                end
            end
        end else begin
            if (bus.start && !bus.abort && m_len >= 1 && m_len <= 8) begin
                m_run = 1; m_cnt = 0; el = 0; m_done = 0; m_tmo = 0;
                q.delete();
            end
            if (bus.cfg_we) begin
                m_pat = bus.cfg_pattern;
                m_len = int'(bus.cfg_len);
                m_ovl = bus.cfg_overlap;
                m_tgt = int'(bus.cfg_target);
                m_lim = int'(bus.cfg_timeout);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("detect", 32'(bus.detect), 32'(m_det));
        chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        chk("busy", 32'(bus.busy), 32'(m_run));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("timeout", 32'(bus.timeout), 32'(m_tmo));
    endtask

    task automatic cyc(input logic st, input logic ab, input logic xb, input logic xv);
        @(negedge clk);
        bus.start = st; bus.abort = ab; bus.x = xb; bus.x_valid = xv;
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cfg(input int pat, input int len, input int ovl, input int tgt, input int lim);
        bus.cfg_pattern = 8'(pat); bus.cfg_len = 4'(len); bus.cfg_overlap = 1'(ovl);
        bus.cfg_target = 8'(tgt); bus.cfg_timeout = 16'(lim); bus.cfg_we = 1'b1;
        cyc(0, 0, 0, 0);
        bus.cfg_we = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) cyc(0, 0, v[i], 1);
    endtask

    initial begin
        reset = 1'b0;
        bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
        bus.cfg_target = 0; bus.cfg_timeout = 0;
        bus.start = 0; bus.abort = 0; bus.x = 0; bus.x_valid = 0;
        m_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // reset defaults, overlapping 1010
        cyc(1, 0, 0, 0);
        feed(6, 32'h15);
        chk("t1_cnt", 32'(bus.match_cnt), 32'd2);
        chk("t1_busy", 32'(bus.busy), 32'd1);

        // non-overlapping
        cyc(0, 1, 0, 0);
        cfg(10, 4, 0, 0, 0);
        cyc(1, 0, 0, 0);
        feed(6, 32'h15);
        chk("t2_cnt", 32'(bus.match_cnt), 32'd1);

        // target reached
        cyc(0, 1, 0, 0);
        cfg(3, 2, 1, 3, 0);
        cyc(1, 0, 0, 0);
        feed(4, 32'hF);
        chk("t3_done", 32'(bus.done), 32'd1);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        feed(1, 32'h1);
        chk("t3_cnt", 32'(bus.match_cnt), 32'd3);

        // inactivity timeout then restart
        cfg(3, 2, 1, 0, 10);
        cyc(1, 0, 0, 0);
        repeat (9) cyc(0, 0, 0, 0);
        chk("t4_pre_tmo", 32'(bus.timeout), 32'd0);
        cyc(0, 0, 0, 0);
        chk("t4_tmo", 32'(bus.timeout), 32'(TMO_EN));
        cyc(1, 0, 0, 0);
        chk("t4_restart_tmo", 32'(bus.timeout), 32'd0);
        chk("t4_restart_busy", 32'(bus.busy), 32'd1);
        cyc(0, 1, 0, 0);

        // abort on completing bit, cfg write during run ignored
        cfg(10, 4, 1, 0, 0);
        cyc(1, 0, 0, 0);
        feed(3, 32'h5);
        cyc(0, 1, 0, 1);
        chk("t5_cnt", 32'(bus.match_cnt), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        cyc(1, 0, 0, 0);
        cfg(5, 4, 0, 1, 3);
        feed(4, 32'h5);
        chk("t5_keep_cnt", 32'(bus.match_cnt), 32'd1);

        // asynchronous reset mid-run restores defaults
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        feed(6, 32'h15);
        chk("t6_pre_cnt", 32'(bus.match_cnt), 32'd2);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        bus.cfg_pattern = 8'h33; bus.cfg_len = 4'd2;
        cyc(1, 0, 0, 0);
        feed(4, 32'h5);
        chk("t6_default_cnt", 32'(bus.match_cnt), 32'd1);

        // saturation with unlimited target
        cyc(0, 1, 0, 0);
        cfg(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (258) cyc(0, 0, 1, 1);
        chk("sat_cnt", 32'(bus.match_cnt), 32'd255);
        cyc(0, 1, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.cfg_we = ($urandom_range(9) == 0);
            if (bus.cfg_we) begin
                bus.cfg_pattern = 8'($urandom);
                bus.cfg_len = 4'($urandom_range(4));
                bus.cfg_overlap = 1'($urandom);
                bus.cfg_target = 8'($urandom_range(3));
                bus.cfg_timeout = 16'($urandom_range(20));
            end
            cyc($urandom_range(7) == 0, $urandom_range(39) == 0, 1'($urandom), $urandom_range(3) != 0);
        end
        bus.cfg_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detection controller for the team's sequence-detector datapath. It holds a runtime pattern and length and scans a qualified serial bit stream in overlapping or non-overlapping mode. It counts matches up to a target, supervises inactivity with a timeout, and reports status through a small FSM. Software configures the block while it is idle, arms it with start, and polls busy, done and timeout.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter and target
TMO_W, 16, width of the timeout counter and limit

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cfg_we  in  1  write all cfg_* fields; honoured only outside RUN
cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit
cfg_len  in  $clog2(PAT_W+1)  pattern length; valid range 1..PAT_W
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNT_W  match count that ends a run; 0 = unlimited
cfg_timeout  in  TMO_W  inactivity limit in cycles; 0 = disabled
start  in  1  arm request, single-cycle pulse
abort  in  1  stop request
x  in  1  serial data bit
x_valid  in  1  x is sampled only when this is high
detect  out  1  one-cycle match pulse
match_cnt  out  CNT_W  matches since the last start
busy  out  1  high in RUN
done  out  1  sticky; target reached
timeout  out  1  sticky; inactivity limit hit

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - state IDLE; detect, match_cnt, busy, done, timeout, history, fill and timer all 0.
  - Configuration defaults: pattern = 'b1010 (zero-extended), len = 4, overlap = 1, target = 0, timeout limit = 0.
- States:
  - IDLE to RUN on start when 1 <= len <= PAT_W. Otherwise start is ignored.
  - RUN to DONE when a match brings match_cnt to target (target != 0).
  - RUN to TMO when the timer expires.
  - RUN to IDLE on abort.
  - DONE/TMO to RUN on start. DONE/TMO to IDLE on abort.
- Start:
  - Clears match_cnt, history, fill, timer, done and timeout.
  - Ignored while in RUN.
- Configuration: cfg_we in RUN is ignored; the stored configuration is unchanged.
- Sampling in RUN, on each x_valid:
  - history <= {history[PAT_W-2:0], x}.
  - fill <= min(fill+1, PAT_W).
- Match: x_valid && (fill+1 >= len) && low len bits of {history, x} equal low len bits of the pattern.
- Match effects:
  - detect is registered: it is high for exactly the cycle after the edge that sampled the completing bit (latency 1).
  - match_cnt increments on the same edge. It saturates at all-ones when target = 0.
- Non-overlap mode: a match sets fill to 0, so the next match needs len fresh bits. Overlap mode keeps fill.
- Timer:
  - Increments every clk in RUN, whether or not x_valid is high.
  - Clears on start and on every match.
  - Expiry: timer == cfg_timeout-1 with no match this cycle. timeout asserts exactly cfg_timeout cycles after the start edge when no match occurs.
  - A match on the expiry cycle wins; no timeout is raised.
- Simultaneous events:
  - abort + completing bit in the same cycle: abort wins. No detect, no count change, go to IDLE.
  - Target reached and timer expiry in the same cycle: go to DONE.
- Outside RUN:
  - x and x_valid are ignored; detect = 0.
  - match_cnt holds its value.
  - done/timeout hold until the next start or reset.

Optional Feature:
SEQ_DET_CTRL_TIMEOUT_EN
- Defined: the timer, cfg_timeout register and TMO state are implemented as specified above.
- Undefined: no timer logic is built. cfg_timeout is ignored, the timeout output is tied 0, and TMO is unreachable. All other behaviour is identical.

Test Plan:
1. Defaults (1010, overlap), start, then x = 1,0,1,0,1,0 on consecutive valid cycles -> detect pulses after bits 4 and 6; match_cnt = 2; busy = 1.
2. Same stream with cfg_overlap = 0 -> a single detect after bit 4; match_cnt = 1.
3. pattern = 'b11, len = 2, target = 3, start, x = 1,1,1,1,1 -> detect after bits 2, 3 and 4; done = 1 and busy = 0 after bit 4; bit 5 gives no detect; match_cnt = 3.
4. timeout = 10, start, x_valid held 0 -> timeout = 1 exactly 10 cycles after the start edge; then start -> timeout = 0, busy = 1.
5. Defaults, bits 1,0,1 then abort together with the completing 0 -> no detect, match_cnt = 0, IDLE. A cfg_we pulse during RUN leaves the pattern unchanged.
6. Reset driven low mid-run, with match_cnt = 2 and busy = 1 -> all outputs 0 before the next clk edge; configuration returns to the 1010 defaults.
